// File: rtl/imem_prog_if.sv
// Load and fetch bus of the programmable instruction memory.
// The master side is the program loader plus the IF stage. The slave side is imem_prog.
interface imem_prog_if #(
    parameter int ADDR_W = 8
);
    logic              clear_req;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_ready;
    logic              load_end;
    logic [ADDR_W:0]   load_count;
    logic              load_ovf;
    logic              busy;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [31:0]       fetch_addr;
    logic              fetch_rvalid;
    logic [31:0]       fetch_instr;
    logic              fetch_fault;

    modport master (
        output clear_req, load_start, load_base, load_valid, load_data, load_end,
               fetch_valid, fetch_addr,
        input  load_ready, load_count, load_ovf, busy, fetch_ready,
               fetch_rvalid, fetch_instr, fetch_fault
    );

    modport slave (
        input  clear_req, load_start, load_base, load_valid, load_data, load_end,
               fetch_valid, fetch_addr,
        output load_ready, load_count, load_ovf, busy, fetch_ready,
               fetch_rvalid, fetch_instr, fetch_fault
    );
endinterface

// File: rtl/imem_prog.sv
// Programmable instruction memory. It has a streaming loader, a hardware zeroing sweep and a registered fetch.
// state | meaning
// CLEAR | zero one word per cycle, cptr 0..DEPTH-1, fetch held off
// IDLE  | serve fetches, accept load_start / clear_req
// LOAD  | accept load words at wptr, fetch held off
module imem_prog #(
    parameter int          ADDR_W         = 8,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [31:0] FAULT_INSTR    = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    imem_prog_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t            state, state_nxt;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wptr, cptr;
    logic [ADDR_W:0]   load_count;
    logic              load_ovf;
    logic              load_ready, busy, handshake, load_full;
    logic              load_wr, clear_wr, fetch_acc, fetch_bad;
    logic [ADDR_W-1:0] fetch_idx;
    logic              fetch_rvalid, fetch_fault;
    logic [31:0]       fetch_instr;

    assign load_ready = (state == S_LOAD);
    assign busy       = (state != S_IDLE);
    assign handshake  = bus.load_valid & load_ready;
    // load_count saturates at DEPTH, so its MSB alone marks "full"
    assign load_full  = load_count[ADDR_W];
    assign load_wr    = handshake & ~load_full;
    assign clear_wr   = (state == S_CLEAR);
    assign fetch_acc  = bus.fetch_valid & ~busy;
    assign fetch_idx  = bus.fetch_addr[ADDR_W+1:2];
    assign fetch_bad  = (|bus.fetch_addr[1:0]) | (|bus.fetch_addr[31:ADDR_W+2]);

    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (&cptr) state_nxt = S_IDLE;
            S_IDLE: begin
                if (bus.load_start)     state_nxt = S_LOAD;
                else if (bus.clear_req) state_nxt = S_CLEAR;
            end
            S_LOAD:  if (bus.load_end) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RESET_STATE;
            wptr         <= '0;
            cptr         <= '0;
            load_count   <= '0;
            load_ovf     <= 1'b0;
            fetch_rvalid <= 1'b0;
            fetch_instr  <= '0;
            fetch_fault  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) cptr <= cptr + 1'b1;
            if (state == S_IDLE) begin
                if (bus.load_start) begin
                    wptr       <= bus.load_base;
                    load_count <= '0;
                    load_ovf   <= 1'b0;
                end else if (bus.clear_req) begin
                    cptr <= '0;
                end
            end
            if (load_wr) begin
                wptr       <= wptr + 1'b1;
                load_count <= load_count + 1'b1;
            end else if (handshake) begin
                load_ovf <= 1'b1;
            end
            fetch_rvalid <= fetch_acc;
            fetch_fault  <= fetch_acc & fetch_bad;
            if (fetch_acc) fetch_instr <= fetch_bad ? FAULT_INSTR : mem[fetch_idx];
        end
    end

    // Storage has no reset, so loaded words survive a reset that skips the sweep
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clear_wr)     mem[cptr] <= '0;
            else if (load_wr) mem[wptr] <= bus.load_data;
        end
    end

    assign bus.load_ready   = load_ready;
    assign bus.load_count   = load_count;
    assign bus.load_ovf     = load_ovf;
    assign bus.busy         = busy;
    assign bus.fetch_ready  = ~busy;
    assign bus.fetch_rvalid = fetch_rvalid;
    assign bus.fetch_instr  = fetch_instr;
    assign bus.fetch_fault  = fetch_fault;
endmodule
